// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: shares the single VGA adapter pixel-write port between
// NUM_CLIENTS drawing engines. A granted client owns the port until its burst
// ends, so redraws never interleave. Accepted pixels reach the adapter one
// cycle later through registered X/Y/color/plot outputs.
// Optional build macro VGA_ARB_ROUND_ROBIN_EN: round-robin winner selection
// starting at rr_ptr instead of fixed priority (index 0 highest).
module vga_draw_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int COLOR_W     = 3
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_CLIENTS-1:0]         req,
  input  logic [NUM_CLIENTS-1:0]         pix_valid,
  input  logic [NUM_CLIENTS-1:0]         pix_last,
  input  logic [NUM_CLIENTS*X_W-1:0]     pix_x,
  input  logic [NUM_CLIENTS*Y_W-1:0]     pix_y,
  input  logic [NUM_CLIENTS*COLOR_W-1:0] pix_color,
  output logic [NUM_CLIENTS-1:0]         grant,
  output logic [NUM_CLIENTS-1:0]         burst_done,
  output logic                           busy,
  output logic                           plot,
  output logic [X_W-1:0]                 X,
  output logic [Y_W-1:0]                 Y,
  output logic [COLOR_W-1:0]             color
);

  localparam int PTR_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  // First requesting index at or after 'start', searching upward cyclically.
  function automatic logic [PTR_W-1:0] pick_winner(
    input logic [NUM_CLIENTS-1:0] r,
    input logic [PTR_W-1:0]       start
  );
    logic [2*NUM_CLIENTS-1:0] dbl;
    logic [NUM_CLIENTS-1:0]   rot;
    int                       off;
    int                       sum;
    dbl = {r, r} >> start;
    rot = dbl[NUM_CLIENTS-1:0];
    off = 0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i;
      end else begin
        off = off;
      end
    end
    sum = int'(start) + off;
    if (sum >= NUM_CLIENTS) begin
      sum = sum - NUM_CLIENTS;
    end else begin
      sum = sum;
    end
    return PTR_W'(sum);
  endfunction

  // (idx + 1) mod NUM_CLIENTS without a divider.
  function automatic logic [PTR_W-1:0] next_index(input logic [PTR_W-1:0] idx);
    int sum;
    sum = int'(idx) + 1;
    if (sum >= NUM_CLIENTS) begin
      sum = 0;
    end else begin
      sum = sum;
    end
    return PTR_W'(sum);
  endfunction

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [NUM_CLIENTS-1:0] burst_done_q, burst_done_d;
  logic                   busy_q, busy_d;
  logic                   plot_q, plot_d;
  logic [X_W-1:0]         x_q, x_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic [COLOR_W-1:0]     color_q, color_d;

`ifdef VGA_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
`endif

  logic                   own_req_s;
  logic                   own_valid_s;
  logic                   own_last_s;
  logic [X_W-1:0]         own_x_s;
  logic [Y_W-1:0]         own_y_s;
  logic [COLOR_W-1:0]     own_color_s;
  logic                   accept_s;
  logic                   burst_end_s;
  logic [PTR_W-1:0]       search_start_s;
  logic [PTR_W-1:0]       winner_s;

  // AND-OR mux of the current owner's request and pixel fields.
  always_comb begin
    own_req_s   = 1'b0;
    own_valid_s = 1'b0;
    own_last_s  = 1'b0;
    own_x_s     = '0;
    own_y_s     = '0;
    own_color_s = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      own_req_s   = own_req_s   | (req[i]       & (owner_q == PTR_W'(i)));
      own_valid_s = own_valid_s | (pix_valid[i] & (owner_q == PTR_W'(i)));
      own_last_s  = own_last_s  | (pix_last[i]  & (owner_q == PTR_W'(i)));
      own_x_s     = own_x_s | (pix_x[i*X_W +: X_W] & {X_W{owner_q == PTR_W'(i)}});
      own_y_s     = own_y_s | (pix_y[i*Y_W +: Y_W] & {Y_W{owner_q == PTR_W'(i)}});
      own_color_s = own_color_s |
                    (pix_color[i*COLOR_W +: COLOR_W] & {COLOR_W{owner_q == PTR_W'(i)}});
    end
  end

  // A pixel presented without its request is dropped; losing req ends the burst.
  always_comb begin
    accept_s    = own_valid_s & own_req_s;
    burst_end_s = (~own_req_s) | (accept_s & own_last_s);
`ifdef VGA_ARB_ROUND_ROBIN_EN
    search_start_s = rr_ptr_q;
`else
    search_start_s = '0;
`endif
    winner_s = pick_winner(req, search_start_s);
  end

  // Arbitration FSM next-state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    grant_d      = '0;
    burst_done_d = '0;
    busy_d       = 1'b0;
    plot_d       = 1'b0;
    x_d          = x_q;
    y_d          = y_q;
    color_d      = color_q;
`ifdef VGA_ARB_ROUND_ROBIN_EN
    rr_ptr_d     = rr_ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = winner_s;
          grant_d = NUM_CLIENTS'(1'b1) << winner_s;
          busy_d  = 1'b1;
          state_d = S_OWNED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OWNED: begin
        if (accept_s) begin
          plot_d  = 1'b1;
          x_d     = own_x_s;
          y_d     = own_y_s;
          color_d = own_color_s;
        end else begin
          plot_d  = 1'b0;
        end
        if (burst_end_s) begin
          burst_done_d = grant_q;
          state_d      = S_IDLE;
`ifdef VGA_ARB_ROUND_ROBIN_EN
          rr_ptr_d     = next_index(owner_q);
`endif
        end else begin
          grant_d = grant_q;
          busy_d  = 1'b1;
          state_d = S_OWNED;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      grant_q      <= '0;
      burst_done_q <= '0;
      busy_q       <= 1'b0;
      plot_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      color_q      <= '0;
`ifdef VGA_ARB_ROUND_ROBIN_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      burst_done_q <= burst_done_d;
      busy_q       <= busy_d;
      plot_q       <= plot_d;
      x_q          <= x_d;
      y_q          <= y_d;
      color_q      <= color_d;
`ifdef VGA_ARB_ROUND_ROBIN_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign burst_done = burst_done_q;
  assign busy       = busy_q;
  assign plot       = plot_q;
  assign X          = x_q;
  assign Y          = y_q;
  assign color      = color_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed testbench for vga_draw_arbiter (NUM_CLIENTS=4, X_W=9, Y_W=8,
// COLOR_W=3). Expected values are hand-derived; round-robin expectations
// are selected by VGA_ARB_ROUND_ROBIN_EN.
module tb_vga_draw_arbiter;

  localparam int N  = 4;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  logic            clock;
  logic            reset;
  logic [N-1:0]    req;
  logic [N-1:0]    pix_valid;
  logic [N-1:0]    pix_last;
  logic [N*XW-1:0] pix_x;
  logic [N*YW-1:0] pix_y;
  logic [N*CW-1:0] pix_color;
  logic [N-1:0]    grant;
  logic [N-1:0]    burst_done;
  logic            busy;
  logic            plot;
  logic [XW-1:0]   X;
  logic [YW-1:0]   Y;
  logic [CW-1:0]   color;

  int checks;
  int errors;

  vga_draw_arbiter #(
    .NUM_CLIENTS(N), .X_W(XW), .Y_W(YW), .COLOR_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .pix_valid(pix_valid),
    .pix_last(pix_last), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .grant(grant), .burst_done(burst_done), .busy(busy), .plot(plot),
    .X(X), .Y(Y), .color(color)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [3:0] g, input logic b,
                         input logic p, input logic [3:0] d);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".plot"}, 32'(plot), 32'(p));
    chk({tag, ".done"}, 32'(burst_done), 32'(d));
  endtask

  task automatic chk_pix(input string tag, input int x, input int y, input int c);
    chk({tag, ".X"}, 32'(X), 32'(x));
    chk({tag, ".Y"}, 32'(Y), 32'(y));
    chk({tag, ".color"}, 32'(color), 32'(c));
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int c,
                         input logic v, input logic l);
    pix_x[i*XW +: XW]     = XW'(x);
    pix_y[i*YW +: YW]     = YW'(y);
    pix_color[i*CW +: CW] = CW'(c);
    pix_valid[i]          = v;
    pix_last[i]           = l;
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [3:0] rr_exp [4];

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    req       = 4'b0000;
    pix_valid = 4'b0000;
    pix_last  = 4'b0000;
    pix_x     = '0;
    pix_y     = '0;
    pix_color = '0;

    // Reset with every client requesting: everything stays 0.
    req = 4'b1111;
    step();
    step();
    chk_ctl("rst", 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk_pix("rst", 0, 0, 0);
    reset = 1'b0;
    step();
    chk_ctl("post_rst", 4'b0001, 1'b1, 1'b0, 4'b0000);
    req = 4'b0000;
    step();
    chk_ctl("rel0", 4'b0000, 1'b0, 1'b0, 4'b0001);
    step();
    chk_ctl("idle0", 4'b0000, 1'b0, 1'b0, 4'b0000);

    // Client 1: three-pixel burst.
    req = 4'b0010;
    step();
    chk_ctl("c1_grant", 4'b0010, 1'b1, 1'b0, 4'b0000);
    set_pix(1, 10, 20, 5, 1'b1, 1'b0);
    step();
    chk_ctl("c1_p0", 4'b0010, 1'b1, 1'b1, 4'b0000);
    chk_pix("c1_p0", 10, 20, 5);
    set_pix(1, 11, 20, 5, 1'b1, 1'b0);
    step();
    chk_ctl("c1_p1", 4'b0010, 1'b1, 1'b1, 4'b0000);
    chk_pix("c1_p1", 11, 20, 5);
    set_pix(1, 12, 20, 5, 1'b1, 1'b1);
    step();
    chk_ctl("c1_p2", 4'b0000, 1'b0, 1'b1, 4'b0010);
    chk_pix("c1_p2", 12, 20, 5);
    set_pix(1, 0, 0, 0, 1'b0, 1'b0);
    req = 4'b0000;
    step();
    chk_ctl("c1_after", 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk_pix("c1_hold", 12, 20, 5);

    // Clients 1 and 2 together; client 2 floods X=300 while client 1 owns.
    pulse_reset();
    req = 4'b0110;
    set_pix(2, 300, 7, 1, 1'b1, 1'b0);
    step();
    chk_ctl("flood_grant", 4'b0010, 1'b1, 1'b0, 4'b0000);
    set_pix(1, 50, 60, 2, 1'b1, 1'b0);
    step();
    chk_ctl("flood_p0", 4'b0010, 1'b1, 1'b1, 4'b0000);
    chk_pix("flood_p0", 50, 60, 2);
    set_pix(1, 0, 0, 0, 1'b0, 1'b0);
    step();
    chk_ctl("flood_gap", 4'b0010, 1'b1, 1'b0, 4'b0000);
    chk_pix("flood_hold", 50, 60, 2);
    set_pix(1, 51, 60, 2, 1'b1, 1'b1);
    step();
    chk_ctl("flood_p1", 4'b0000, 1'b0, 1'b1, 4'b0010);
    chk_pix("flood_p1", 51, 60, 2);
    set_pix(1, 0, 0, 0, 1'b0, 1'b0);
    req = 4'b0100;
    step();
    chk_ctl("c2_grant", 4'b0100, 1'b1, 1'b0, 4'b0000);
    set_pix(2, 300, 7, 1, 1'b1, 1'b1);
    step();
    chk_ctl("c2_p0", 4'b0000, 1'b0, 1'b1, 4'b0100);
    chk_pix("c2_p0", 300, 7, 1);
    set_pix(2, 0, 0, 0, 1'b0, 1'b0);
    req = 4'b0000;
    step();

    // Client 0 drops req after 2 of 5 pixels; client 3 waits.
    pulse_reset();
    req = 4'b1001;
    step();
    chk_ctl("c0_grant", 4'b0001, 1'b1, 1'b0, 4'b0000);
    set_pix(0, 100, 50, 3, 1'b1, 1'b0);
    step();
    chk_ctl("c0_p0", 4'b0001, 1'b1, 1'b1, 4'b0000);
    chk_pix("c0_p0", 100, 50, 3);
    set_pix(0, 101, 50, 3, 1'b1, 1'b0);
    step();
    chk_ctl("c0_p1", 4'b0001, 1'b1, 1'b1, 4'b0000);
    chk_pix("c0_p1", 101, 50, 3);
    set_pix(0, 102, 50, 3, 1'b1, 1'b0);
    req = 4'b1000;
    step();
    chk_ctl("c0_drop", 4'b0000, 1'b0, 1'b0, 4'b0001);
    chk_pix("c0_drop", 101, 50, 3);
    set_pix(0, 0, 0, 0, 1'b0, 1'b0);
    step();
    chk_ctl("c3_grant", 4'b1000, 1'b1, 1'b0, 4'b0000);

    // Reset while client 3 is mid-burst.
    set_pix(3, 7, 8, 6, 1'b1, 1'b0);
    step();
    chk_ctl("c3_p0", 4'b1000, 1'b1, 1'b1, 4'b0000);
    chk_pix("c3_p0", 7, 8, 6);
    reset = 1'b1;
    step();
    chk_ctl("c3_rst", 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk_pix("c3_rst", 0, 0, 0);
    reset = 1'b0;
    set_pix(3, 0, 0, 0, 1'b0, 1'b0);
    step();
    chk_ctl("c3_rearb", 4'b1000, 1'b1, 1'b0, 4'b0000);
    req = 4'b0000;
    step();
    chk_ctl("c3_rel", 4'b0000, 1'b0, 1'b0, 4'b1000);
    step();

    // Single-pixel bursts with req held at 1011; X carries the client index.
`ifdef VGA_ARB_ROUND_ROBIN_EN
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b1000; rr_exp[3] = 4'b0001;
`else
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0001; rr_exp[2] = 4'b0001; rr_exp[3] = 4'b0001;
`endif
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      set_pix(i, 200 + i, 10 + i, i, 1'b1, 1'b1);
    end
    req = 4'b1011;
    for (int b = 0; b < 4; b++) begin
      step();
      chk_ctl($sformatf("rr%0d_grant", b), rr_exp[b], 1'b1, 1'b0, 4'b0000);
      step();
      chk_ctl($sformatf("rr%0d_done", b), 4'b0000, 1'b0, 1'b1, rr_exp[b]);
      chk_pix($sformatf("rr%0d", b), 200 + $clog2(int'(rr_exp[b])),
              10 + $clog2(int'(rr_exp[b])), $clog2(int'(rr_exp[b])));
    end
    req       = 4'b0000;
    pix_valid = 4'b0000;
    pix_last  = 4'b0000;
    step();
    chk_ctl("final_idle", 4'b0000, 1'b0, 1'b0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_draw_arbiter.md
Name: vga_draw_arbiter

Overview:
- Parametrised successor to the hard-wired sprite/map plot mux in the top level.
- Arbitrates between NUM_CLIENTS drawing engines (map drawer, sprite drawer, future HUD/text engines) competing for the single VGA adapter pixel-write port.
- A granted client keeps the port until its burst ends, so redraws are never interleaved.
- Pixel path is registered: one pixel per clock, fixed 1-cycle latency to the adapter.

Parameters:
- NUM_CLIENTS, 4, number of drawing clients (1..8); index 0 = highest fixed priority.
- X_W, 9, X coordinate width.
- Y_W, 8, Y coordinate width.
- COLOR_W, 3, colour width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_CLIENTS  per-client bus request; held high for the whole burst.
- pix_valid  in  NUM_CLIENTS  client presents a pixel this cycle.
- pix_last  in  NUM_CLIENTS  qualifies pix_valid: final pixel of the burst.
- pix_x  in  NUM_CLIENTS*X_W  flattened X; client i occupies bits [i*X_W +: X_W].
- pix_y  in  NUM_CLIENTS*Y_W  flattened Y, same packing.
- pix_color  in  NUM_CLIENTS*COLOR_W  flattened colour, same packing.
- grant  out  NUM_CLIENTS  one-hot grant, registered.
- burst_done  out  NUM_CLIENTS  1-cycle pulse to the client whose burst just ended.
- busy  out  1  high while any grant is held.
- plot  out  1  write strobe to the VGA adapter.
- X  out  X_W  adapter X coordinate.
- Y  out  Y_W  adapter Y coordinate.
- color  out  COLOR_W  adapter colour.

Behaviour:
- Reset values: all outputs are 0; FSM state is IDLE; round-robin pointer is 0.
- FSM states:
  - IDLE
    - If any req bit is high, select a winner.
    - Next cycle: grant = onehot(winner), busy = 1, go to OWNED.
    - If no req is high, stay in IDLE with grant = 0.
  - OWNED (owner index k)
    - Accepted pixel: pix_valid[k] = 1. On the next cycle, plot = 1 and X/Y/color = client k's fields from the accepting cycle.
    - No accepted pixel: plot = 0 next cycle; X/Y/color hold their last value.
    - Burst end is either of:
      - an accepted pixel with pix_last[k] = 1 (that pixel is still plotted);
      - req[k] sampled low.
    - On burst end, the next cycle has grant = 0, busy = 0, burst_done[k] = 1, and the FSM returns to IDLE.
- Arbitration gap: at least one IDLE cycle between bursts. Back-to-back bursts from the same client therefore have grant low for exactly one cycle.
- pix_valid, pix_last and pixel fields from non-granted clients are ignored and never reach the outputs.
- Default policy is fixed priority: the lowest requesting index wins.
- Requests arriving during OWNED do not pre-empt the owner. They are evaluated in the next IDLE cycle.
- pix_valid[k] with req[k] low in the same cycle: the pixel is dropped (no plot) and the burst ends.
- Reset mid-burst: on the next edge grant, plot and busy are 0, burst_done is not pulsed, and the FSM is in IDLE.
- NUM_CLIENTS = 1 must synthesise. The winner is always index 0.
- No width conversion: fields pass through bit-exact.

Optional Feature:
- Macro: VGA_ARB_ROUND_ROBIN_EN.
- Defined:
  - Winner = first requesting index at or after rr_ptr, searching cyclically upward and wrapping at NUM_CLIENTS-1 → 0.
  - On every burst end, rr_ptr becomes (owner+1) mod NUM_CLIENTS.
  - reset clears rr_ptr to 0.
- Undefined: fixed priority as above, and no rr_ptr register exists.

Test Plan:
- Reset with req = 4'b1111 asserted → all outputs 0 that cycle. One cycle after reset drops, grant = 4'b0001 and busy = 1.
- Client 1 owns and sends 3 pixels (10,20,c=5), (11,20,c=5), (12,20,c=5), the last with pix_last → plot high exactly 3 cycles, each 1 cycle after acceptance with matching X/Y/color. burst_done = 4'b0010 one cycle after the last acceptance; grant = 0 in that cycle.
- req = 4'b0110 together; client 2 floods pix_valid with X = 300 while client 1 owns → no plot carries X = 300. Client 2 is granted only after client 1's burst_done plus the one-cycle IDLE gap.
- Client 0 drops req mid-burst after 2 of 5 pixels → exactly 2 plots. burst_done[0] pulses, then the next requester is granted.
- Reset asserted while client 3 owns mid-burst → next cycle grant = 0, plot = 0, no burst_done pulse; the FSM re-arbitrates normally afterwards.
- With VGA_ARB_ROUND_ROBIN_EN defined and req held at 4'b1011 over single-pixel bursts → grant sequence is 0001, 0010, 1000, 0001. Without the macro, every grant is 0001.
